mdu_issue_ctrl: RTL and testbench

Sequencer for the E-stage multiply/divide unit. Accepts MDU operations from the decode/execute boundary with a valid/ready handshake and issues one operation per accepted request. It tracks multiply (5-cycle) and divide (10-cycle) occupancy in its own FSM and produces the pipeline stall, the issue strobe and the HI/LO commit strobe. It also supports flush-abort of an in-flight operation and keeps a free-running busy-cycle counter for performance measurement.

---
 rtl/mdu_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - E-stage multiply/divide issue sequencer
//
// Accepts MDU operations at the decode/execute boundary, issues one op per
// accepted request, tracks multiply/divide occupancy, and produces the
// pipeline stall, the issue strobe and the HI/LO commit strobe. Supports
// flush-abort of an in-flight op and a free-running busy-cycle counter.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   req_valid    E-stage instruction carries an MDU op
//   req_op       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                7 mfhi, 8 mflo, 9-15 none
//   flush        cancel in-flight op and suppress this cycle's issue
//   req_ready    controller can accept req_op this cycle
//   stall        hold the D and E stages
//   issue        one-cycle strobe: op handed to the MDU
//   mdu_op       req_op when issue=1, else 0
//   commit       one-cycle strobe: MDU writes temp result into HI/LO
//   busy         mult/div in flight
//   cnt          remaining busy cycles
//   busy_cycles  count of cycles with busy=1, wraps

module mdu_issue_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic        flush,
   output logic        req_ready,
   output logic        stall,
   output logic        issue,
   output logic [3:0]  mdu_op,
   output logic        commit,
   output logic        busy,
   output logic [3:0]  cnt,
   output logic [31:0] busy_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] busy_cycles_q, busy_cycles_d;

   logic op_valid;
   logic is_mul;
   logic is_div;

   assign op_valid = req_valid && (req_op >= 4'd1) && (req_op <= 4'd8);
   assign is_mul   = (req_op == 4'd1) || (req_op == 4'd2);
   assign is_div   = (req_op == 4'd3) || (req_op == 4'd4);

   assign busy        = (state_q != S_IDLE);
   assign cnt         = cnt_q;
   assign busy_cycles = busy_cycles_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      busy_cycles_d = busy ? busy_cycles_q + 32'd1 : busy_cycles_q;
      req_ready     = (state_q == S_IDLE);
      issue         = 1'b0;
      mdu_op        = 4'd0;
      commit        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (op_valid && !flush) begin
               issue  = 1'b1;
               mdu_op = req_op;
               if (is_mul) begin
                  state_d = S_MUL;
                  cnt_d   = MUL_CNT;
               end else if (is_div) begin
                  state_d = S_DIV;
                  cnt_d   = DIV_CNT;
               end
            end
         end
         default: begin
            if (flush) begin
               // Aborted op never reaches HI/LO, even on its final cycle.
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               // A reset in the final cycle also discards the result.
               commit  = !reset;
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase

      // Not gated by flush: the pipeline resolves flush with priority.
      stall = op_valid && !req_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         busy_cycles_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         busy_cycles_q <= busy_cycles_d;
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - self-checking bench for mdu_issue_ctrl

module tb_mdu_issue_ctrl;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [3:0]  req_op;
   logic        flush;
   logic        req_ready;
   logic        stall;
   logic        issue;
   logic [3:0]  mdu_op;
   logic        commit;
   logic        busy;
   logic [3:0]  cnt;
   logic [31:0] busy_cycles;

   mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .flush       (flush),
      .req_ready   (req_ready),
      .stall       (stall),
      .issue       (issue),
      .mdu_op      (mdu_op),
      .commit      (commit),
      .busy        (busy),
      .cnt         (cnt),
      .busy_cycles (busy_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: an accepted mult/div occupies the unit through the
   // absolute cycle index busy_end; everything else follows from that.
   int          cyc      = 0;
   int          busy_end = -1;
   logic [31:0] bc_m     = 32'd0;
   logic        c_v, c_fl, c_rst, c_iss;
   logic [3:0]  c_op;

   typedef struct {
      logic        v;
      logic [3:0]  op;
      logic        fl;
      logic        e_issue;
      logic [3:0]  e_op;
      logic        e_stall;
      logic        e_commit;
      logic        e_busy;
      logic [3:0]  e_cnt;
      logic [31:0] e_bc;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic cyc_begin(input logic v, input logic [3:0] op, input logic fl, input logic rst);
      logic        busy_m, ready_m, vop;
      logic [12:0] exp_vec, act_vec;
      req_valid = v;
      req_op    = op;
      flush     = fl;
      reset     = rst;
      c_v = v; c_op = op; c_fl = fl; c_rst = rst;
      @(negedge clk);
      busy_m  = (cyc <= busy_end);
      ready_m = !busy_m;
      vop     = v && (op >= 4'd1) && (op <= 4'd8);
      c_iss   = ready_m && vop && !fl;
      exp_vec = {ready_m, vop && !ready_m, c_iss, c_iss ? op : 4'd0,
                 busy_m && (cyc == busy_end) && !fl && !rst, busy_m,
                 busy_m ? 4'(busy_end - cyc + 1) : 4'd0};
      act_vec = {req_ready, stall, issue, mdu_op, commit, busy, cnt};
      chk("model_outputs", 32'(act_vec), 32'(exp_vec));
      chk("model_busy_cycles", busy_cycles, bc_m);
   endtask

   task automatic cyc_end();
      logic busy_m;
      @(posedge clk);
      busy_m = (cyc <= busy_end);
      if (c_rst) begin
         busy_end = cyc;
         bc_m     = 32'd0;
      end else begin
         if (busy_m) bc_m = bc_m + 32'd1;
         if (busy_m && c_fl) busy_end = cyc;
         if (c_iss && (c_op == 4'd1 || c_op == 4'd2)) busy_end = cyc + MUL_LAT;
         if (c_iss && (c_op == 4'd3 || c_op == 4'd4)) busy_end = cyc + DIV_LAT;
      end
      cyc++;
      #1;
   endtask

   task automatic idle_cycle();
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b0);
      cyc_end();
   endtask

   task automatic reset_cycle();
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b1);
      cyc_end();
   endtask

   initial begin
      // mult timeline, single-cycle ops, out-of-range ops
      tbl[0]  = '{1'b1, 4'd1,  1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0};
      tbl[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 32'd0};
      tbl[2]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 32'd1};
      tbl[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 32'd2};
      tbl[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 32'd3};
      tbl[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 32'd4};
      tbl[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};
      tbl[7]  = '{1'b1, 4'd5,  1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};
      tbl[8]  = '{1'b1, 4'd6,  1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};
      tbl[9]  = '{1'b1, 4'd7,  1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};
      tbl[10] = '{1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};
      tbl[11] = '{1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5};

      req_valid = 1'b0;
      req_op    = 4'd0;
      flush     = 1'b0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state, with reset still asserted
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b1);
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_cnt", 32'(cnt), 32'd0);
      chk("reset_commit", 32'(commit), 32'd0);
      cyc_end();

      for (int i = 0; i < 12; i++) begin
         cyc_begin(tbl[i].v, tbl[i].op, tbl[i].fl, 1'b0);
         chk($sformatf("tbl%0d_issue", i), 32'(issue), 32'(tbl[i].e_issue));
         chk($sformatf("tbl%0d_mdu_op", i), 32'(mdu_op), 32'(tbl[i].e_op));
         chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_commit", i), 32'(commit), 32'(tbl[i].e_commit));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_busy_cycles", i), busy_cycles, tbl[i].e_bc);
         cyc_end();
      end

      // divu, then mflo held valid through the busy window
      reset_cycle();
      cyc_begin(1'b1, 4'd4, 1'b0, 1'b0);
      chk("divu_issue", 32'(issue), 32'd1);
      cyc_end();
      for (int k = 1; k <= 10; k++) begin
         cyc_begin(1'b1, 4'd8, 1'b0, 1'b0);
         chk($sformatf("mflo_stall_c%0d", k), 32'(stall), 32'd1);
         chk($sformatf("mflo_noissue_c%0d", k), 32'(issue), 32'd0);
         chk($sformatf("divu_commit_c%0d", k), 32'(commit), (k == 10) ? 32'd1 : 32'd0);
         cyc_end();
      end
      cyc_begin(1'b1, 4'd8, 1'b0, 1'b0);
      chk("mflo_issue", 32'(issue), 32'd1);
      chk("mflo_mdu_op", 32'(mdu_op), 32'd8);
      chk("mflo_stall", 32'(stall), 32'd0);
      chk("divu_busy_cycles", busy_cycles, 32'd10);
      cyc_end();

      // div, flush in cycle 4, new mult in cycle 5
      reset_cycle();
      cyc_begin(1'b1, 4'd3, 1'b0, 1'b0);
      cyc_end();
      for (int k = 1; k <= 3; k++) begin
         cyc_begin(1'b0, 4'd0, 1'b0, 1'b0);
         chk($sformatf("divfl_commit_c%0d", k), 32'(commit), 32'd0);
         cyc_end();
      end
      cyc_begin(1'b0, 4'd0, 1'b1, 1'b0);
      chk("divfl_commit_c4", 32'(commit), 32'd0);
      cyc_end();
      cyc_begin(1'b1, 4'd1, 1'b0, 1'b0);
      chk("divfl_busy_c5", 32'(busy), 32'd0);
      chk("divfl_cnt_c5", 32'(cnt), 32'd0);
      chk("divfl_mult_issue", 32'(issue), 32'd1);
      cyc_end();
      repeat (6) idle_cycle();

      // mult, flush on the cnt==1 cycle
      reset_cycle();
      cyc_begin(1'b1, 4'd2, 1'b0, 1'b0);
      cyc_end();
      repeat (4) idle_cycle();
      cyc_begin(1'b0, 4'd0, 1'b1, 1'b0);
      chk("mulfl_cnt_c5", 32'(cnt), 32'd1);
      chk("mulfl_commit_c5", 32'(commit), 32'd0);
      cyc_end();
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b0);
      chk("mulfl_busy_c6", 32'(busy), 32'd0);
      chk("mulfl_ready_c6", 32'(req_ready), 32'd1);
      cyc_end();

      // back-to-back mult held valid: second issues in T+6
      cyc_begin(1'b1, 4'd1, 1'b0, 1'b0);
      chk("b2b_first_issue", 32'(issue), 32'd1);
      cyc_end();
      for (int k = 1; k <= 6; k++) begin
         cyc_begin(1'b1, 4'd1, 1'b0, 1'b0);
         chk($sformatf("b2b_issue_c%0d", k), 32'(issue), (k == 6) ? 32'd1 : 32'd0);
         cyc_end();
      end
      repeat (6) idle_cycle();

      // reset in cycle 3 of a div
      cyc_begin(1'b1, 4'd3, 1'b0, 1'b0);
      cyc_end();
      repeat (2) idle_cycle();
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b1);
      chk("divrst_commit_c3", 32'(commit), 32'd0);
      cyc_end();
      cyc_begin(1'b0, 4'd0, 1'b0, 1'b0);
      chk("divrst_busy_c4", 32'(busy), 32'd0);
      chk("divrst_bc_c4", busy_cycles, 32'd0);
      chk("divrst_commit_c4", 32'(commit), 32'd0);
      cyc_end();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic       rv, rf, rr;
         logic [3:0] ro;
         rv = ($urandom_range(0, 3) != 0);
         ro = 4'($urandom_range(0, 15));
         rf = ($urandom_range(0, 9) == 0);
         rr = ($urandom_range(0, 99) == 0);
         cyc_begin(rv, ro, rf, rr);
         cyc_end();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
